// File: rtl/data_mem.sv
// Word-organised data memory for the MEM stage: zero-latency loads, address legality checks,
// a sticky first-fault record and saturating committed load/store counters.
module data_mem #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        fault_clr,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr,
   output logic        fault_we,
   output logic [15:0] ld_cnt,
   output logic [15:0] st_cnt
);

   logic [31:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              misaligned;
   logic              out_of_range;
   logic              legal;
   logic              illegal;
   logic              wr_en;

   logic              fault_q, fault_d;
   logic [1:0]        fault_cause_q, fault_cause_d;
   logic [31:0]       fault_addr_q, fault_addr_d;
   logic              fault_we_q, fault_we_d;
   logic [15:0]       ld_cnt_q, ld_cnt_d;
   logic [15:0]       st_cnt_q, st_cnt_d;

   always_comb begin
      idx          = addr[ADDR_W+1:2];
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = (addr[31:ADDR_W+2] != '0);
      legal        = ce & ~misaligned & ~out_of_range;
      illegal      = ce & ~legal;
      wr_en        = legal & we;
   end

   // Loads read the array directly; stores, illegal accesses, idle cycles and reset read as 0.
   always_comb begin
      rdata = 32'h0;
      if (!rst && legal && !we) begin
         rdata = mem_q[idx];
      end
   end

   // A clear in the same cycle as a new fault lets that fault become the first record.
   always_comb begin
      fault_d       = fault_q;
      fault_cause_d = fault_cause_q;
      fault_addr_d  = fault_addr_q;
      fault_we_d    = fault_we_q;
      if (fault_clr) begin
         fault_d       = 1'b0;
         fault_cause_d = 2'b00;
         fault_addr_d  = 32'h0;
         fault_we_d    = 1'b0;
      end
      if (illegal && !fault_d) begin
         fault_d       = 1'b1;
         fault_cause_d = {out_of_range, misaligned};
         fault_addr_d  = addr;
         fault_we_d    = we;
      end
   end

   always_comb begin
      ld_cnt_d = ld_cnt_q;
      st_cnt_d = st_cnt_q;
      if (legal && !we && (ld_cnt_q != 16'hFFFF)) begin
         ld_cnt_d = ld_cnt_q + 16'd1;
      end
      if (legal && we && (st_cnt_q != 16'hFFFF)) begin
         st_cnt_d = st_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q       <= 1'b0;
         fault_cause_q <= 2'b00;
         fault_addr_q  <= 32'h0;
         fault_we_q    <= 1'b0;
         ld_cnt_q      <= 16'h0;
         st_cnt_q      <= 16'h0;
      end else begin
         fault_q       <= fault_d;
         fault_cause_q <= fault_cause_d;
         fault_addr_q  <= fault_addr_d;
         fault_we_q    <= fault_we_d;
         ld_cnt_q      <= ld_cnt_d;
         st_cnt_q      <= st_cnt_d;
      end
   end

   // Contents are cleared on reset, so the array is built from resettable flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else if (wr_en) begin
         mem_q[idx] <= wdata;
      end
   end

   assign fault       = fault_q;
   assign fault_cause = fault_cause_q;
   assign fault_addr  = fault_addr_q;
   assign fault_we    = fault_we_q;
   assign ld_cnt      = ld_cnt_q;
   assign st_cnt      = st_cnt_q;

endmodule

// File: doc/data_mem.md
# data_mem

Word-organised data memory sitting directly downstream of the pipeline's MEM stage. It consumes the MEM stage's `memCe`, `memWrite`, `memAddr` and `memwriteData` and returns `memreadData` in the same cycle, so loads complete without stalling. It also enforces address legality, records the first faulting access, and keeps committed load and store counters for debug and performance visibility.

## Interface

Parameters:
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two, minimum 4.
- `ADDR_W`, default 10: log2(`DEPTH`); word index width.

Ports:
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `ce` input, 1 bit: access enable (from MEM `memCe`).
- `we` input, 1 bit: write enable (from MEM `memWrite`); meaningful only when `ce`=1.
- `addr` input, 32 bits: byte address (from MEM `memAddr`).
- `wdata` input, 32 bits: store data (from MEM `memwriteData`).
- `rdata` output, 32 bits: load data (to MEM `memreadData`); combinational.
- `fault_clr` input, 1 bit: clears the sticky fault record.
- `fault` output, 1 bit: sticky fault flag.
- `fault_cause` output, 2 bits: bit0 = misaligned, bit1 = out of range.
- `fault_addr` output, 32 bits: byte address of the captured faulting access.
- `fault_we` output, 1 bit: 1 if the captured faulting access was a store.
- `ld_cnt` output, 16 bits: committed load count, saturating.
- `st_cnt` output, 16 bits: committed store count, saturating.

## Operation

- Word index is `addr[ADDR_W+1:2]`.
- Misaligned: `addr[1:0] != 0`.
- Out of range: `addr[31:ADDR_W+2] != 0`.
- Legal access: `ce`=1, not misaligned, not out of range.
- Load (`ce`=1, `we`=0):
  - Legal: `rdata` = mem[index].
  - Illegal: `rdata` = 0.
- `ce`=0: `rdata` = 0 regardless of `we` and `addr`.
- Store (`ce`=1, `we`=1):
  - Legal: mem[index] is written with `wdata` at the clock edge.
  - Illegal: the array is unchanged.
  - `rdata` = 0 during any store cycle.
- Fault record, updated when `ce`=1 and the access is illegal:
  - `fault`=0: set `fault`=1 and capture `fault_cause`, `fault_addr` and `fault_we`.
  - `fault`=1: keep the first record; later faults are ignored.
- `fault_clr`=1 clears `fault`, `fault_cause`, `fault_addr` and `fault_we` to 0.
- `fault_clr` in the same cycle as a new illegal access: the new fault is captured (clear, then set).
- Counters:
  - `ld_cnt` increments on each legal load; `st_cnt` increments on each legal store.
  - Both hold at 0xFFFF and never wrap.
  - Faulting accesses are not counted.
- `we`=1 with `ce`=0 is a no-op: no write, no fault, no count.

## Timing

- Reset (`rst`=1 at an edge):
  - Every memory word is cleared to 0.
  - `fault`, `fault_cause`, `fault_addr`, `fault_we`, `ld_cnt`, `st_cnt` all become 0.
  - `rst` overrides every other input in that cycle, including a store that is in flight.
- While `rst` is high, `rdata` is 0.
- Read latency is 0 cycles: `rdata` is combinational from `ce`, `we`, `addr` and array contents.
- Write latency is 1 edge: data stored at edge N is visible to a load in cycle N+1.
- There is no same-cycle write-to-read bypass. A single port cannot load and store in the same cycle.
- Fault capture and counter updates happen at the same edge as the access.
- `fault_clr` takes effect at the next edge.

## Test plan

- Reset, then store and load:
  - Stimulus: store 0xDEADBEEF at 0x10, then load 0x10.
  - Required: `rdata`=0xDEADBEEF in the load cycle; `st_cnt`=1 and `ld_cnt`=1 after the load edge.
  - Stimulus: load 0x14.
  - Required: `rdata`=0 (reset contents).
- Misaligned store:
  - Stimulus: store 0x12345678 to 0x22.
  - Required: word 0x20 unchanged; `fault`=1, `fault_cause`=01, `fault_addr`=0x22, `fault_we`=1; `st_cnt` unchanged.
- Out-of-range load with a sticky record (`DEPTH`=1024):
  - Stimulus: load 0x00001000.
  - Required: `rdata`=0, `fault_cause`=10, `fault_we`=0.
  - Stimulus: a later load at 0x3 while `fault`=1.
  - Required: the record still shows 0x00001000.
  - Stimulus: `fault_clr` together with a load at 0x3.
  - Required: record becomes cause=01, addr=0x3.
- Counter saturation:
  - Stimulus: 65,537 legal loads.
  - Required: `ld_cnt`=0xFFFF, never wraps to 0; `st_cnt`=0.
- Reset mid-operation:
  - Stimulus: store 0xA5A5A5A5 to 0x40 in the same cycle `rst`=1.
  - Required: word 0x40 reads 0 afterwards, all counters and `fault` are 0.
- `ce`=0 with `we`=1:
  - Stimulus: addr 0x2, `wdata`=0xFFFFFFFF.
  - Required: no fault, no count, word 0 unchanged, `rdata`=0.
